// File: rtl/partition_dispatch_if.sv
// Instruction, core and response channels of the partition dispatcher.
// master = dispatcher side, slave = environment (instruction source, core, response sink).
interface partition_dispatch_if #(
    parameter int REGION_WIDTH = 64
);
    logic                    instr_valid;
    logic                    instr_ready;
    logic [7:0]              instr_op;
    logic [7:0]              instr_a;
    logic [7:0]              instr_b;
    logic [REGION_WIDTH-1:0] instr_region;
    logic [7:0]              core_op;
    logic                    core_op_valid;
    logic [REGION_WIDTH-1:0] core_pnew_region;
    logic [7:0]              core_psplit_module_id;
    logic [REGION_WIDTH-1:0] core_psplit_mask;
    logic [7:0]              core_pmerge_m1;
    logic [7:0]              core_pmerge_m2;
    logic                    core_op_done;
    logic [7:0]              core_result_module_id;
    logic [7:0]              core_num_modules;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [7:0]              resp_module_id;
    logic                    resp_err;
    logic                    resp_timeout;
    logic [15:0]             issued_count;
    logic [15:0]             rejected_count;
    logic                    halted;

    modport master (
        input  instr_valid, instr_op, instr_a, instr_b, instr_region,
        output instr_ready,
        output core_op, core_op_valid, core_pnew_region, core_psplit_module_id,
        output core_psplit_mask, core_pmerge_m1, core_pmerge_m2,
        input  core_op_done, core_result_module_id, core_num_modules,
        output resp_valid, resp_module_id, resp_err, resp_timeout,
        input  resp_ready,
        output issued_count, rejected_count, halted
    );

    modport slave (
        output instr_valid, instr_op, instr_a, instr_b, instr_region,
        input  instr_ready,
        input  core_op, core_op_valid, core_pnew_region, core_psplit_module_id,
        input  core_psplit_mask, core_pmerge_m1, core_pmerge_m2,
        output core_op_done, core_result_module_id, core_num_modules,
        input  resp_valid, resp_module_id, resp_err, resp_timeout,
        output resp_ready,
        input  issued_count, rejected_count, halted
    );
endinterface

// File: rtl/partition_dispatch.sv
// Partition instruction dispatcher: queues instructions, prechecks them against the
// core module count, issues one op at a time to the core and returns one response each.
module partition_dispatch #(
    parameter int FIFO_DEPTH   = 4,
    parameter int REGION_WIDTH = 64,
    parameter int MAX_MODULES  = 8,
    parameter int TIMEOUT      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    partition_dispatch_if.master bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] WAIT_LAST_C = TW'(TIMEOUT - 1);
    localparam logic [7:0]    MAX_MOD_C   = 8'(MAX_MODULES);

    localparam logic [7:0] OP_PNEW   = 8'h00;
    localparam logic [7:0] OP_PSPLIT = 8'h01;
    localparam logic [7:0] OP_PMERGE = 8'h02;
    localparam logic [7:0] OP_MDLACC = 8'h05;
    localparam logic [7:0] OP_HALT   = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_RESP   = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    function automatic logic op_is_legal(input logic [7:0] op);
        logic legal;
        case (op)
            OP_PNEW, OP_PSPLIT, OP_PMERGE, OP_MDLACC, OP_HALT: legal = 1'b1;
            default:                                          legal = 1'b0;
        endcase
        return legal;
    endfunction

    // A module id is valid only below the current count; a split also needs room for one more.
    function automatic logic precheck_fail(input logic [7:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic [7:0] n);
        logic fail;
        case (op)
            OP_PNEW:   fail = (n >= MAX_MOD_C);
            OP_PSPLIT: fail = (a >= n) || (n >= MAX_MOD_C);
            OP_PMERGE: fail = (a >= n) || (b >= n) || (a == b);
            default:   fail = 1'b0;
        endcase
        return fail;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

    state_t state_r, state_s;

    logic [7:0]              op_mem_r     [FIFO_DEPTH];
    logic [7:0]              a_mem_r      [FIFO_DEPTH];
    logic [7:0]              b_mem_r      [FIFO_DEPTH];
    logic [REGION_WIDTH-1:0] region_mem_r [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]           count_r, count_s;
    logic                    halt_seen_r, halt_seen_s;
    logic                    instr_ready_r;
    logic                    push_s, pop_s, empty_s;

    logic [7:0]              head_op_s, head_a_s, head_b_s;
    logic [REGION_WIDTH-1:0] head_region_s;
    logic                    head_halt_s, head_bad_s;

    logic                    issue_s, reject_s, halt_pop_s, done_s, timeout_s, resp_hs_s;
    logic [TW-1:0]           wait_cnt_r;
    logic                    is_halt_r;

    logic [7:0]              core_op_r;
    logic                    core_op_valid_r;
    logic [REGION_WIDTH-1:0] core_pnew_region_r;
    logic [7:0]              core_psplit_module_id_r;
    logic [REGION_WIDTH-1:0] core_psplit_mask_r;
    logic [7:0]              core_pmerge_m1_r;
    logic [7:0]              core_pmerge_m2_r;
    logic                    resp_valid_r;
    logic [7:0]              resp_module_id_r;
    logic                    resp_err_r;
    logic                    resp_timeout_r;
    logic [15:0]             issued_count_r;
    logic [15:0]             rejected_count_r;
    logic                    halted_r;

    assign push_s        = bus.instr_valid && instr_ready_r;
    assign empty_s       = (count_r == {CW{1'b0}});
    assign head_op_s     = op_mem_r[rd_ptr_r];
    assign head_a_s      = a_mem_r[rd_ptr_r];
    assign head_b_s      = b_mem_r[rd_ptr_r];
    assign head_region_s = region_mem_r[rd_ptr_r];
    assign head_halt_s   = (head_op_s == OP_HALT);
    assign head_bad_s    = !op_is_legal(head_op_s) ||
                           precheck_fail(head_op_s, head_a_s, head_b_s, bus.core_num_modules);

    // Queue occupancy and sticky halt flag for the next cycle.
    always_comb begin
        count_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + CW'(1);
            2'b01:   count_s = count_r - CW'(1);
            default: count_s = count_r;
        endcase
        halt_seen_s = halt_seen_r || (push_s && (bus.instr_op == OP_HALT));
    end

    // Queue pointers, occupancy, halt flag and the registered ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r      <= {PW{1'b0}};
            rd_ptr_r      <= {PW{1'b0}};
            count_r       <= {CW{1'b0}};
            halt_seen_r   <= 1'b0;
            instr_ready_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r       <= count_s;
            halt_seen_r   <= halt_seen_s;
            instr_ready_r <= (count_s != DEPTH_C) && !halt_seen_s;
        end
    end

    // Queue storage; contents are don't-care whenever the pointers say empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            op_mem_r[wr_ptr_r]     <= bus.instr_op;
            a_mem_r[wr_ptr_r]      <= bus.instr_a;
            b_mem_r[wr_ptr_r]      <= bus.instr_b;
            region_mem_r[wr_ptr_r] <= bus.instr_region;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    state_s = (head_halt_s || head_bad_s) ? ST_RESP : ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_s = ST_WAIT;
            ST_WAIT: begin
                if (bus.core_op_done || (wait_cnt_r == WAIT_LAST_C)) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_s = is_halt_r ? ST_HALTED : ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            ST_HALTED: state_s = ST_HALTED;
            default:   state_s = ST_IDLE;
        endcase
    end

    // FSM output strobes that steer the datapath registers.
    always_comb begin
        pop_s      = 1'b0;
        issue_s    = 1'b0;
        reject_s   = 1'b0;
        halt_pop_s = 1'b0;
        done_s     = 1'b0;
        timeout_s  = 1'b0;
        resp_hs_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s = 1'b1;
                    if (head_halt_s) begin
                        halt_pop_s = 1'b1;
                    end else if (head_bad_s) begin
                        reject_s = 1'b1;
                    end else begin
                        issue_s = 1'b1;
                    end
                end else begin
                    pop_s = 1'b0;
                end
            end
            ST_WAIT: begin
                if (bus.core_op_done) begin
                    done_s = 1'b1;
                end else if (wait_cnt_r == WAIT_LAST_C) begin
                    timeout_s = 1'b1;
                end else begin
                    done_s = 1'b0;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    resp_hs_s = 1'b1;
                end else begin
                    resp_hs_s = 1'b0;
                end
            end
            default: pop_s = 1'b0;
        endcase
    end

    // Core command registers: loaded at pop, held through WAIT, cleared once WAIT ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_op_valid_r         <= 1'b0;
            core_op_r               <= 8'h00;
            core_pnew_region_r      <= {REGION_WIDTH{1'b0}};
            core_psplit_module_id_r <= 8'h00;
            core_psplit_mask_r      <= {REGION_WIDTH{1'b0}};
            core_pmerge_m1_r        <= 8'h00;
            core_pmerge_m2_r        <= 8'h00;
        end else begin
            core_op_valid_r <= issue_s;
            if (issue_s) begin
                core_op_r               <= head_op_s;
                core_pnew_region_r      <= (head_op_s == OP_PNEW)   ? head_region_s : {REGION_WIDTH{1'b0}};
                core_psplit_module_id_r <= (head_op_s == OP_PSPLIT) ? head_a_s      : 8'h00;
                core_psplit_mask_r      <= (head_op_s == OP_PSPLIT) ? head_region_s : {REGION_WIDTH{1'b0}};
                core_pmerge_m1_r        <= (head_op_s == OP_PMERGE) ? head_a_s      : 8'h00;
                core_pmerge_m2_r        <= (head_op_s == OP_PMERGE) ? head_b_s      : 8'h00;
            end else if (done_s || timeout_s) begin
                core_op_r               <= 8'h00;
                core_pnew_region_r      <= {REGION_WIDTH{1'b0}};
                core_psplit_module_id_r <= 8'h00;
                core_psplit_mask_r      <= {REGION_WIDTH{1'b0}};
                core_pmerge_m1_r        <= 8'h00;
                core_pmerge_m2_r        <= 8'h00;
            end
        end
    end

    // Response registers, wait counter, counters and halted flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_r     <= 1'b0;
            resp_module_id_r <= 8'h00;
            resp_err_r       <= 1'b0;
            resp_timeout_r   <= 1'b0;
            issued_count_r   <= 16'h0000;
            rejected_count_r <= 16'h0000;
            wait_cnt_r       <= {TW{1'b0}};
            is_halt_r        <= 1'b0;
            halted_r         <= 1'b0;
        end else begin
            wait_cnt_r <= (state_r == ST_WAIT) ? (wait_cnt_r + TW'(1)) : {TW{1'b0}};
            if (state_r == ST_ISSUE) begin
                issued_count_r <= sat_inc(issued_count_r);
            end
            if (reject_s || timeout_s) begin
                rejected_count_r <= sat_inc(rejected_count_r);
            end
            if (done_s) begin
                resp_valid_r     <= 1'b1;
                resp_module_id_r <= bus.core_result_module_id;
                resp_err_r       <= 1'b0;
                resp_timeout_r   <= 1'b0;
            end else if (timeout_s || reject_s || halt_pop_s) begin
                resp_valid_r     <= 1'b1;
                resp_module_id_r <= 8'h00;
                resp_err_r       <= timeout_s || reject_s;
                resp_timeout_r   <= timeout_s;
            end else if (resp_hs_s) begin
                resp_valid_r     <= 1'b0;
                resp_module_id_r <= 8'h00;
                resp_err_r       <= 1'b0;
                resp_timeout_r   <= 1'b0;
            end
            if (halt_pop_s) begin
                is_halt_r <= 1'b1;
            end else if (resp_hs_s) begin
                is_halt_r <= 1'b0;
            end
            halted_r <= (state_s == ST_HALTED);
        end
    end

    assign bus.instr_ready           = instr_ready_r;
    assign bus.core_op               = core_op_r;
    assign bus.core_op_valid         = core_op_valid_r;
    assign bus.core_pnew_region      = core_pnew_region_r;
    assign bus.core_psplit_module_id = core_psplit_module_id_r;
    assign bus.core_psplit_mask      = core_psplit_mask_r;
    assign bus.core_pmerge_m1        = core_pmerge_m1_r;
    assign bus.core_pmerge_m2        = core_pmerge_m2_r;
    assign bus.resp_valid            = resp_valid_r;
    assign bus.resp_module_id        = resp_module_id_r;
    assign bus.resp_err              = resp_err_r;
    assign bus.resp_timeout          = resp_timeout_r;
    assign bus.issued_count          = issued_count_r;
    assign bus.rejected_count        = rejected_count_r;
    assign bus.halted                = halted_r;
endmodule

// File: tb/tb_partition_dispatch.sv
// Directed bench for partition_dispatch; a small core model answers 3 cycles after
// each issue with result = pnew_region[15:8] ^ psplit_mask[15:8].
module tb_partition_dispatch;
    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ov_count = 0;
    int   ov0;
    logic       core_en;
    logic       inj_done;
    logic       model_done = 1'b0;
    logic [2:0] pipe       = 3'b000;
    logic [7:0] model_id   = 8'h00;
    logic [7:0] cap_id     = 8'h00;

    partition_dispatch_if #(.REGION_WIDTH(64)) bus ();

    partition_dispatch #(
        .FIFO_DEPTH(4), .REGION_WIDTH(64), .MAX_MODULES(8), .TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    assign bus.core_op_done          = model_done | inj_done;
    assign bus.core_result_module_id = inj_done ? 8'h09 : model_id;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.core_op_valid) ov_count <= ov_count + 1;
    end

    always @(negedge clk) begin
        if (rst) begin
            pipe       <= 3'b000;
            model_done <= 1'b0;
        end else begin
            model_done <= pipe[2];
            if (pipe[2]) model_id <= cap_id;
            pipe <= {pipe[1:0], bus.core_op_valid & core_en};
            if (bus.core_op_valid) cap_id <= bus.core_pnew_region[15:8] ^ bus.core_psplit_mask[15:8];
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of test, expected $finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [63:0] region);
        int t;
        t = 0;
        bus.instr_op     = op;
        bus.instr_a      = a;
        bus.instr_b      = b;
        bus.instr_region = region;
        bus.instr_valid  = 1'b1;
        while (!bus.instr_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("push_ready", 64'(bus.instr_ready), 64'd1);
        @(negedge clk);
        bus.instr_valid = 1'b0;
    endtask

    task automatic wait_opv(input string tag, input int exp_cycles);
        int c;
        c = 0;
        while (!bus.core_op_valid && c < 40) begin
            @(negedge clk);
            c++;
        end
        check(tag, 64'(c), 64'(exp_cycles));
    endtask

    task automatic wait_resp(input string tag, input int exp_cycles);
        int c;
        c = 0;
        while (!bus.resp_valid && c < 60) begin
            @(negedge clk);
            c++;
        end
        check(tag, 64'(c), 64'(exp_cycles));
    endtask

    task automatic retire();
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("resp_drop", 64'(bus.resp_valid), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        core_en = 1'b1;
        inj_done = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr_op = 8'h00;
        bus.instr_a = 8'h00;
        bus.instr_b = 8'h00;
        bus.instr_region = 64'h0;
        bus.resp_ready = 1'b0;
        bus.core_num_modules = 8'd0;

        // Reset values, then ready one cycle after release
        @(negedge clk);
        check("rst_ready", 64'(bus.instr_ready), 64'd0);
        check("rst_opv", 64'(bus.core_op_valid), 64'd0);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_issued", 64'(bus.issued_count), 64'd0);
        check("rst_halted", 64'(bus.halted), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'(bus.instr_ready), 64'd1);

        // PNEW region 0x0F, core returns id 0
        push(8'h00, 8'h00, 8'h00, 64'h0F);
        wait_opv("pnew_pop_to_issue", 1);
        check("pnew_core_op", 64'(bus.core_op), 64'h00);
        check("pnew_region", bus.core_pnew_region, 64'h0F);
        check("pnew_mask_unused", bus.core_psplit_mask, 64'h0);
        wait_resp("pnew_issue_to_resp", 4);
        check("pnew_resp_id", 64'(bus.resp_module_id), 64'h00);
        check("pnew_resp_err", 64'(bus.resp_err), 64'd0);
        check("pnew_issued", 64'(bus.issued_count), 64'd1);
        retire();

        // PSPLIT a=1 mask 0x05F0 with 3 modules, core returns id 5
        bus.core_num_modules = 8'd3;
        push(8'h01, 8'h01, 8'h00, 64'h05F0);
        wait_opv("psplit_pop_to_issue", 1);
        check("psplit_core_op", 64'(bus.core_op), 64'h01);
        check("psplit_id", 64'(bus.core_psplit_module_id), 64'h01);
        check("psplit_mask", bus.core_psplit_mask, 64'h05F0);
        check("psplit_region_unused", bus.core_pnew_region, 64'h0);
        wait_resp("psplit_issue_to_resp", 4);
        check("psplit_resp_id", 64'(bus.resp_module_id), 64'h05);
        check("psplit_issued", 64'(bus.issued_count), 64'd2);
        retire();

        // PMERGE a == b is rejected without issuing
        ov0 = ov_count;
        push(8'h02, 8'h01, 8'h01, 64'h0);
        wait_resp("pmerge_rej_latency", 1);
        check("pmerge_err", 64'(bus.resp_err), 64'd1);
        check("pmerge_timeout", 64'(bus.resp_timeout), 64'd0);
        check("pmerge_rejected", 64'(bus.rejected_count), 64'd1);
        check("pmerge_no_issue", 64'(ov_count), 64'(ov0));
        retire();

        // Illegal opcode, then PNEW with the core already at capacity
        push(8'h07, 8'h00, 8'h00, 64'h0);
        wait_resp("illegal_latency", 1);
        check("illegal_err", 64'(bus.resp_err), 64'd1);
        check("illegal_rejected", 64'(bus.rejected_count), 64'd2);
        retire();
        bus.core_num_modules = 8'd8;
        push(8'h00, 8'h00, 8'h00, 64'h0300);
        wait_resp("pnew_full_latency", 1);
        check("pnew_full_err", 64'(bus.resp_err), 64'd1);
        check("pnew_full_rejected", 64'(bus.rejected_count), 64'd3);
        check("pnew_full_no_issue", 64'(ov_count), 64'(ov0));
        retire();

        // MDLACC with a silent core times out; a late done is ignored
        core_en = 1'b0;
        push(8'h05, 8'h00, 8'h00, 64'h0);
        wait_opv("mdlacc_pop_to_issue", 1);
        repeat (10) @(negedge clk);
        check("mdlacc_op_held", 64'(bus.core_op), 64'h05);
        check("mdlacc_pulse_once", 64'(bus.core_op_valid), 64'd0);
        wait_resp("mdlacc_timeout_at", 7);
        check("to_err", 64'(bus.resp_err), 64'd1);
        check("to_flag", 64'(bus.resp_timeout), 64'd1);
        check("to_id", 64'(bus.resp_module_id), 64'h00);
        check("to_rejected", 64'(bus.rejected_count), 64'd4);
        check("to_issued", 64'(bus.issued_count), 64'd3);
        repeat (2) @(negedge clk);
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        check("late_done_id", 64'(bus.resp_module_id), 64'h00);
        check("late_done_valid", 64'(bus.resp_valid), 64'd1);
        check("late_done_to", 64'(bus.resp_timeout), 64'd1);
        core_en = 1'b1;
        retire();

        // Five back-to-back PNEWs with resp_ready low fill the queue behind one in flight
        bus.core_num_modules = 8'd0;
        for (int k = 1; k <= 5; k++) begin
            push(8'h00, 8'h00, 8'h00, 64'(k) << 8);
        end
        check("full_ready_low", 64'(bus.instr_ready), 64'd0);
        wait_resp("b2b_first_resp", 1);
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) wait_resp("b2b_next_resp", 5);
            check("b2b_resp_id", 64'(bus.resp_module_id), 64'(k));
            check("b2b_resp_err", 64'(bus.resp_err), 64'd0);
            if (k == 2) check("b2b_ready_back", 64'(bus.instr_ready), 64'd1);
            retire();
        end
        check("b2b_issued", 64'(bus.issued_count), 64'd8);

        // Reset in WAIT of a PSPLIT with another instruction queued
        core_en = 1'b0;
        bus.core_num_modules = 8'd2;
        push(8'h01, 8'h01, 8'h00, 64'h0300);
        wait_opv("rstw_issue", 1);
        push(8'h00, 8'h00, 8'h00, 64'h0800);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstw_ready", 64'(bus.instr_ready), 64'd0);
        check("rstw_core_op", 64'(bus.core_op), 64'h00);
        check("rstw_psplit_id", 64'(bus.core_psplit_module_id), 64'h00);
        check("rstw_mask", bus.core_psplit_mask, 64'h0);
        check("rstw_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rstw_issued", 64'(bus.issued_count), 64'd0);
        check("rstw_rejected", 64'(bus.rejected_count), 64'd0);
        @(negedge clk);
        check("rstw_ready_back", 64'(bus.instr_ready), 64'd1);
        ov0 = ov_count;
        repeat (5) @(negedge clk);
        check("rstw_fifo_empty", 64'(ov_count), 64'(ov0));
        check("rstw_no_resp", 64'(bus.resp_valid), 64'd0);
        core_en = 1'b1;
        bus.core_num_modules = 8'd0;
        push(8'h00, 8'h00, 8'h00, 64'h0700);
        wait_opv("post_rst_issue", 1);
        wait_resp("post_rst_resp", 4);
        check("post_rst_id", 64'(bus.resp_module_id), 64'h07);
        check("post_rst_issued", 64'(bus.issued_count), 64'd1);
        retire();

        // HALT blocks further input, retires cleanly and is terminal
        push(8'hFF, 8'h00, 8'h00, 64'h0);
        check("halt_ready_low", 64'(bus.instr_ready), 64'd0);
        bus.instr_op = 8'h00;
        bus.instr_region = 64'h0200;
        bus.instr_valid = 1'b1;
        ov0 = ov_count;
        wait_resp("halt_resp", 1);
        check("halt_err", 64'(bus.resp_err), 64'd0);
        check("halt_not_yet", 64'(bus.halted), 64'd0);
        retire();
        check("halted_set", 64'(bus.halted), 64'd1);
        repeat (8) @(negedge clk);
        check("halted_no_issue", 64'(ov_count), 64'(ov0));
        check("halted_ready", 64'(bus.instr_ready), 64'd0);
        check("halted_stays", 64'(bus.halted), 64'd1);
        check("halted_issued", 64'(bus.issued_count), 64'd1);
        bus.instr_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("halt_rst_clear", 64'(bus.halted), 64'd0);
        @(negedge clk);
        check("halt_rst_ready", 64'(bus.instr_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
